// File: rtl/seg_lim_tlb_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_lim_tlb_checker                                          |
// | Description : Memory-stage segment-limit and TLB-hit checker. Accepts one  |
// |               access (VA, size) per request handshake. It range-checks     |
// |               VA..VA+size against seg_max and translates the first page,   |
// |               plus a second page for page-crossing accesses, through a     |
// |               flat fully-associative TLB image. It returns a one-hot       |
// |               exception code and the translated PA(s) through a            |
// |               valid/ready response.                                        |
// | Options     : SEG_LIM_PERF_CNT_EN - when defined, adds saturating          |
// |               perf_prot_cnt / perf_pf_cnt response counters.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_lim_tlb_checker #(
  parameter int ADDR_W      = 32,
  parameter int PAGE_W      = 12,
  parameter int PFN_W       = 20,
  parameter int TLB_ENTRIES = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [2:0]                        req_size,
  input  logic [ADDR_W-1:0]                 seg_max,
  input  logic [TLB_ENTRIES*(ADDR_W-PAGE_W)-1:0] tlb_vp,
  input  logic [TLB_ENTRIES*PFN_W-1:0]      tlb_pf,
  input  logic [TLB_ENTRIES-1:0]            tlb_v,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [2:0]                        rsp_exc,
  output logic                              rsp_split,
  output logic [ADDR_W-1:0]                 rsp_pa0,
  output logic [ADDR_W-1:0]                 rsp_pa1
`ifdef SEG_LIM_PERF_CNT_EN
  ,
  output logic [15:0]                       perf_prot_cnt,
  output logic [15:0]                       perf_pf_cnt
`else
`endif
);

  localparam int VPN_W = ADDR_W - PAGE_W;

  localparam logic [2:0] EXC_NONE = 3'b000;
  localparam logic [2:0] EXC_PROT = 3'b001;
  localparam logic [2:0] EXC_PF   = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CHK0 = 2'd1,
    ST_CHK1 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [ADDR_W-1:0]   seg_max_q, seg_max_d;
  // First-page results carried from CHK0 into CHK1 for split accesses
  logic                prot_q, prot_d;
  logic                miss0_q, miss0_d;
  logic [PFN_W-1:0]    pfn0_q, pfn0_d;
  // Registered response fields, held stable while in RESP
  logic [2:0]          exc_q, exc_d;
  logic                split_q, split_d;
  logic [ADDR_W-1:0]   pa0_q, pa0_d;
  logic [ADDR_W-1:0]   pa1_q, pa1_d;

  logic [ADDR_W:0]     end_addr;
  logic [PAGE_W:0]     off_sum;
  logic                prot0;
  logic                split_now;
  logic [VPN_W-1:0]    vpn0;
  logic [VPN_W-1:0]    vpn1;
  logic                vpn_wrap;
  logic [VPN_W-1:0]    lookup_vpn;
  logic [PAGE_W-1:0]   page_off;
  logic [TLB_ENTRIES-1:0] match;
  logic                lk_hit;
  logic [PFN_W-1:0]    lk_pfn;
  logic                prot_fin;
  logic                miss_fin;
  logic                rsp_fire;

  // Range arithmetic on the latched request; one extra bit keeps the carry-out
  assign end_addr  = {1'b0, addr_q} + {{(ADDR_W-2){1'b0}}, size_q};
  assign off_sum   = {1'b0, addr_q[PAGE_W-1:0]} + {{(PAGE_W-2){1'b0}}, size_q};
  assign prot0     = end_addr[ADDR_W] | (end_addr[ADDR_W-1:0] > seg_max_q);
  assign split_now = off_sum[PAGE_W];
  assign page_off  = addr_q[PAGE_W-1:0];
  assign vpn0      = addr_q[ADDR_W-1:PAGE_W];
  assign {vpn_wrap, vpn1} = {1'b0, vpn0} + {{VPN_W{1'b0}}, 1'b1};

  // A single lookup port serves both check cycles; CHK1 searches the next page
  assign lookup_vpn = (state_q == ST_CHK1) ? vpn1 : vpn0;

  generate
    for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_match
      assign match[gi] = tlb_v[gi] && (tlb_vp[gi*VPN_W +: VPN_W] == lookup_vpn);
    end
  endgenerate

  // Priority select among matching entries; the lowest index wins
  always_comb begin
    lk_hit = 1'b0;
    lk_pfn = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (match[i] && !lk_hit) begin
        lk_hit = 1'b1;
        lk_pfn = tlb_pf[i*PFN_W +: PFN_W];
      end
    end
  end

  // Final exception inputs: CHK1 merges page-0 results with page-1 lookup
  always_comb begin
    prot_fin = prot0;
    miss_fin = !lk_hit;
    if (state_q == ST_CHK1) begin
      prot_fin = prot_q | vpn_wrap;
      miss_fin = miss0_q | !lk_hit;
    end
  end

  assign rsp_fire  = (state_q == ST_RESP) && rsp_ready;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_exc   = exc_q;
  assign rsp_split = split_q;
  assign rsp_pa0   = pa0_q;
  assign rsp_pa1   = pa1_q;

  // Next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    seg_max_d = seg_max_q;
    prot_d    = prot_q;
    miss0_d   = miss0_q;
    pfn0_d    = pfn0_q;
    exc_d     = exc_q;
    split_d   = split_q;
    pa0_d     = pa0_q;
    pa1_d     = pa1_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          seg_max_d = seg_max;
          state_d   = ST_CHK0;
        end
      end
      ST_CHK0: begin
        if (split_now) begin
          prot_d  = prot0;
          miss0_d = !lk_hit;
          pfn0_d  = lk_pfn;
          state_d = ST_CHK1;
        end else begin
          exc_d   = prot_fin ? EXC_PROT : (miss_fin ? EXC_PF : EXC_NONE);
          split_d = 1'b0;
          pa0_d   = (prot_fin || miss_fin) ? '0 : {lk_pfn, page_off};
          pa1_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_CHK1: begin
        exc_d   = prot_fin ? EXC_PROT : (miss_fin ? EXC_PF : EXC_NONE);
        split_d = 1'b1;
        pa0_d   = (prot_fin || miss_fin) ? '0 : {pfn0_q, page_off};
        pa1_d   = (prot_fin || miss_fin) ? '0 : {lk_pfn, {PAGE_W{1'b0}}};
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      seg_max_q <= '0;
      prot_q    <= 1'b0;
      miss0_q   <= 1'b0;
      pfn0_q    <= '0;
      exc_q     <= EXC_NONE;
      split_q   <= 1'b0;
      pa0_q     <= '0;
      pa1_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      seg_max_q <= seg_max_d;
      prot_q    <= prot_d;
      miss0_q   <= miss0_d;
      pfn0_q    <= pfn0_d;
      exc_q     <= exc_d;
      split_q   <= split_d;
      pa0_q     <= pa0_d;
      pa1_q     <= pa1_d;
    end
  end

`ifdef SEG_LIM_PERF_CNT_EN
  logic [15:0] prot_cnt_q, prot_cnt_d;
  logic [15:0] pf_cnt_q, pf_cnt_d;

  // Saturating exception counters bumped on each delivered response
  always_comb begin
    prot_cnt_d = prot_cnt_q;
    pf_cnt_d   = pf_cnt_q;
    if (rsp_fire && (exc_q == EXC_PROT) && (prot_cnt_q != 16'hFFFF)) begin
      prot_cnt_d = prot_cnt_q + 16'd1;
    end
    if (rsp_fire && (exc_q == EXC_PF) && (pf_cnt_q != 16'hFFFF)) begin
      pf_cnt_d = pf_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prot_cnt_q <= '0;
      pf_cnt_q   <= '0;
    end else begin
      prot_cnt_q <= prot_cnt_d;
      pf_cnt_q   <= pf_cnt_d;
    end
  end

  assign perf_prot_cnt = prot_cnt_q;
  assign perf_pf_cnt   = pf_cnt_q;
`else
  // Counters not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_lim_tlb_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg_lim_tlb_checker                                       |
// | Description : Scoreboard bench for seg_lim_tlb_checker.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg_lim_tlb_checker;

  localparam int ADDR_W = 32;
  localparam int PAGE_W = 12;
  localparam int PFN_W  = 20;
  localparam int N      = 8;
  localparam int VPN_W  = ADDR_W - PAGE_W;

  typedef struct packed {
    logic [2:0]  exc;
    logic        split;
    logic [31:0] pa0;
    logic [31:0] pa1;
  } resp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = '0;
  logic [2:0]        req_size = '0;
  logic [31:0]       seg_max = '0;
  logic [N*VPN_W-1:0] tlb_vp = '0;
  logic [N*PFN_W-1:0] tlb_pf = '0;
  logic [N-1:0]      tlb_v = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [2:0]        rsp_exc;
  logic              rsp_split;
  logic [31:0]       rsp_pa0;
  logic [31:0]       rsp_pa1;
`ifdef SEG_LIM_PERF_CNT_EN
  logic [15:0]       perf_prot_cnt;
  logic [15:0]       perf_pf_cnt;
  int                exp_prot = 0;
  int                exp_pf   = 0;
`endif

  resp_t sb_q[$];
  int vectors     = 0;
  int miscompares = 0;

  seg_lim_tlb_checker #(
    .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .PFN_W(PFN_W), .TLB_ENTRIES(N)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .seg_max(seg_max),
    .tlb_vp(tlb_vp), .tlb_pf(tlb_pf), .tlb_v(tlb_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_exc(rsp_exc), .rsp_split(rsp_split),
    .rsp_pa0(rsp_pa0), .rsp_pa1(rsp_pa1)
`ifdef SEG_LIM_PERF_CNT_EN
    ,
    .perf_prot_cnt(perf_prot_cnt), .perf_pf_cnt(perf_pf_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic resp_t mk(input logic [2:0] e, input logic s,
                               input logic [31:0] p0, input logic [31:0] p1);
    resp_t r;
    r.exc = e; r.split = s; r.pa0 = p0; r.pa1 = p1;
    return r;
  endfunction

  task automatic clear_tlb();
    tlb_vp = '0; tlb_pf = '0; tlb_v = '0;
  endtask

  task automatic set_entry(input int i, input logic [19:0] vp, input logic [19:0] pf, input logic v);
    tlb_vp[i*VPN_W +: VPN_W] = vp;
    tlb_pf[i*PFN_W +: PFN_W] = pf;
    tlb_v[i] = v;
  endtask

  // Reference lookup: scan the TLB image, first valid match wins
  function automatic logic [20:0] ref_lookup(input logic [19:0] vpn);
    for (int i = 0; i < N; i++) begin
      if (tlb_v[i] && tlb_vp[i*VPN_W +: VPN_W] == vpn)
        return {1'b1, tlb_pf[i*PFN_W +: PFN_W]};
    end
    return 21'd0;
  endfunction

  // Reference model of the whole check
  function automatic resp_t ref_model(input logic [31:0] a, input logic [2:0] s, input logic [31:0] lim);
    longint unsigned last;
    logic prot, split, miss;
    logic [20:0] l0, l1;
    resp_t r;
    last  = longint'(a) + longint'(s);
    prot  = (last > longint'(lim));
    split = ((a & 32'hFFF) + 32'(s)) > 32'hFFF;
    l0    = ref_lookup(a[31:12]);
    l1    = ref_lookup(a[31:12] + 20'd1);
    miss  = !l0[20] || (split && !l1[20]);
    r.split = split;
    r.exc   = prot ? 3'b001 : (miss ? 3'b010 : 3'b000);
    r.pa0   = (prot || miss) ? 32'd0 : {l0[19:0], a[11:0]};
    r.pa1   = (prot || miss || !split) ? 32'd0 : {l1[19:0], 12'h000};
    return r;
  endfunction

  // Issue one request, wait for its response, check it against the scoreboard
  task automatic do_req(input logic [31:0] a, input logic [2:0] s, input logic [31:0] lim,
                        input resp_t e, input int lat_exp, input int hold);
    resp_t want;
    resp_t got;
    int lat;
    sb_q.push_back(e);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_addr = a; req_size = s; seg_max = lim;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    want = sb_q.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_timeout: addr=%h no rsp_valid after %0d edges", a, lat);
      return;
    end
    if (lat != lat_exp) begin
      miscompares++;
      $display("FAIL latency: addr=%h got %0d edges want %0d", a, lat, lat_exp);
    end
    got = {rsp_exc, rsp_split, rsp_pa0, rsp_pa1};
    vectors++;
    if (got.exc !== want.exc || got.split !== want.split) begin
      miscompares++;
      $display("FAIL exc_split: addr=%h got exc=%b split=%b want exc=%b split=%b",
               a, got.exc, got.split, want.exc, want.split);
    end
    vectors++;
    if (got.pa0 !== want.pa0 || got.pa1 !== want.pa1) begin
      miscompares++;
      $display("FAIL pa: addr=%h got pa0=%h pa1=%h want pa0=%h pa1=%h",
               a, got.pa0, got.pa1, want.pa0, want.pa1);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      vectors++;
      if ({rsp_valid, req_ready, rsp_exc, rsp_split, rsp_pa0, rsp_pa1} !== {1'b1, 1'b0, want}) begin
        miscompares++;
        $display("FAIL hold_stable: cycle %0d got v=%b rdy=%b exc=%b pa0=%h want v=1 rdy=0 exc=%b pa0=%h",
                 k, rsp_valid, req_ready, rsp_exc, rsp_pa0, want.exc, want.pa0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
`ifdef SEG_LIM_PERF_CNT_EN
    if (want.exc == 3'b001) exp_prot++;
    if (want.exc == 3'b010) exp_pf++;
`endif
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release: got rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_exc, rsp_split, rsp_pa0, rsp_pa1} !== {1'b1, 1'b0, 3'b000, 1'b0, 64'd0}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b v=%b exc=%b split=%b pa0=%h pa1=%h want 1/0/000/0/0/0",
               req_ready, rsp_valid, rsp_exc, rsp_split, rsp_pa0, rsp_pa1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_hit();
    clear_tlb();
    set_entry(2, 20'h00001, 20'hABCDE, 1'b1);
    do_req(32'h0000_1000, 3'd3, 32'h0000_FFFF, mk(3'b000, 1'b0, 32'hABCDE000, 32'd0), 2, 0);
    // Duplicate VPN in a lower slot must win
    set_entry(1, 20'h00001, 20'h12345, 1'b1);
    do_req(32'h0000_1234, 3'd0, 32'h0000_FFFF, mk(3'b000, 1'b0, 32'h12345234, 32'd0), 2, 0);
  endtask

  task automatic test_split();
    clear_tlb();
    set_entry(0, 20'h00001, 20'h11111, 1'b1);
    set_entry(1, 20'h00002, 20'h22222, 1'b1);
    do_req(32'h0000_1FFE, 3'd3, 32'h0000_FFFF, mk(3'b000, 1'b1, 32'h11111FFE, 32'h22222000), 3, 0);
    // Second page missing -> page fault, split still reported
    set_entry(1, 20'h00002, 20'h22222, 1'b0);
    do_req(32'h0000_1FFE, 3'd3, 32'h0000_FFFF, mk(3'b010, 1'b1, 32'd0, 32'd0), 3, 0);
  endtask

  task automatic test_limit();
    clear_tlb();
    set_entry(3, 20'h0000F, 20'h0F0F0, 1'b1);
    set_entry(4, 20'h00005, 20'h05050, 1'b1);
    do_req(32'h0000_FFFC, 3'd3, 32'h0000_FFFF, mk(3'b000, 1'b0, 32'h0F0F0FFC, 32'd0), 2, 0);
    do_req(32'h0000_FFFC, 3'd3, 32'h0000_FFFE, mk(3'b001, 1'b0, 32'd0, 32'd0), 2, 0);
    do_req(32'h0000_5000, 3'd0, 32'h0000_4FFF, mk(3'b001, 1'b0, 32'd0, 32'd0), 2, 0);
  endtask

  task automatic test_miss();
    clear_tlb();
    set_entry(4, 20'h00003, 20'h33333, 1'b0);
    do_req(32'h0000_3000, 3'd1, 32'h0000_FFFF, mk(3'b010, 1'b0, 32'd0, 32'd0), 2, 0);
    // Protection outranks the miss
    do_req(32'h0000_3000, 3'd1, 32'h0000_2FFF, mk(3'b001, 1'b0, 32'd0, 32'd0), 2, 0);
  endtask

  task automatic test_carry_hold();
    clear_tlb();
    set_entry(0, 20'hFFFFF, 20'h77777, 1'b1);
    set_entry(1, 20'h00000, 20'h88888, 1'b1);
    do_req(32'hFFFF_FFFE, 3'd3, 32'hFFFF_FFFF, mk(3'b001, 1'b1, 32'd0, 32'd0), 3, 5);
    // All-ones limit without carry is legal
    do_req(32'hFFFF_FFF0, 3'd7, 32'hFFFF_FFFF, mk(3'b000, 1'b0, 32'h77777FF0, 32'd0), 2, 0);
  endtask

  task automatic test_rst_mid();
    clear_tlb();
    set_entry(0, 20'h00001, 20'h11111, 1'b1);
    set_entry(1, 20'h00002, 20'h22222, 1'b1);
    req_valid = 1'b1; req_addr = 32'h0000_1FFF; req_size = 3'd1; seg_max = 32'h0000_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_async: got rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef SEG_LIM_PERF_CNT_EN
    exp_prot = 0;
    exp_pf   = 0;
`endif
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_exc !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid_after: got rsp_valid=%b req_ready=%b exc=%b want 0/1/000",
               rsp_valid, req_ready, rsp_exc);
    end
    do_req(32'h0000_1FFF, 3'd1, 32'h0000_FFFF, mk(3'b000, 1'b1, 32'h11111FFF, 32'h22222000), 3, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] lim;
    logic [2:0]  s;
    resp_t e;
    clear_tlb();
    for (int i = 0; i < N; i++) begin
      set_entry(i, 20'(i), 20'h80000 + 20'(i * 'h111), (i != 5));
    end
    for (int n = 0; n < 24; n++) begin
      a   = 32'($urandom_range(0, 32'h7FFF));
      if (n % 4 == 0) a = a | 32'h0000_0FFC;
      s   = 3'($urandom_range(0, 7));
      lim = 32'($urandom_range(32'h4000, 32'h8FFF));
      e   = ref_model(a, s, lim);
      do_req(a, s, lim, e, e.split ? 3 : 2, 0);
    end
  endtask

`ifdef SEG_LIM_PERF_CNT_EN
  task automatic test_perf();
    vectors++;
    if (perf_prot_cnt !== 16'(exp_prot) || perf_pf_cnt !== 16'(exp_pf)) begin
      miscompares++;
      $display("FAIL perf_counts: got prot=%0d pf=%0d want prot=%0d pf=%0d",
               perf_prot_cnt, perf_pf_cnt, exp_prot, exp_pf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_hit();
    test_split();
    test_limit();
    test_miss();
    test_carry_hold();
`ifdef SEG_LIM_PERF_CNT_EN
    test_perf();
`endif
    test_rst_mid();
    test_back_to_back();
`ifdef SEG_LIM_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
